freq_meter_mc: RTL and testbench

FREQ_METER_MC -- requirements
Module: freq_meter_mc

---
 rtl/freq_meter_pkg.sv | 12 +
 rtl/bcd_sat_counter.sv | 58 +++++
 rtl/freq_meter_mc.sv | 99 +++++++++
 tb/tb_freq_meter_mc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the multi-channel BCD frequency meter.
package freq_meter_pkg;

  localparam int unsigned BcdW              = 4;
  localparam int unsigned DefaultGateCycles = 100_000_000;

  // Width of the channel-select port; a single channel still gets one bit.
  function automatic int unsigned sel_width(input int unsigned n_ch);
    return (n_ch > 1) ? int'($clog2(n_ch)) : 1;
  endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Cascaded BCD event counter that saturates at all-9s and raises a sticky overflow flag.
module bcd_sat_counter
  import freq_meter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [BcdW*DIGITS-1:0] count_next,
  output logic                   ovf_next
);

  logic [BcdW*DIGITS-1:0] count_q;
  logic                   ovf_q;
  logic                   all_nines;
  logic                   carry;
  logic [BcdW-1:0]        digit;

  // count_next includes this cycle's edge so a closing window can latch it directly.
  always_comb begin
    count_next = count_q;
    ovf_next   = ovf_q;
    carry      = inc;
    all_nines  = 1'b1;
    digit      = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (count_q[d*BcdW +: BcdW] != 4'd9) all_nines = 1'b0;
    end
    if (inc && all_nines) begin
      ovf_next = 1'b1;
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        digit = count_q[d*BcdW +: BcdW];
        if (carry) begin
          if (digit == 4'd9) begin
            count_next[d*BcdW +: BcdW] = '0;
          end else begin
            count_next[d*BcdW +: BcdW] = digit + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      ovf_q   <= ovf_next;
    end
  end

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency meter: synchronised edge counting per channel,
// results latched at each gate window end and muxed to a BCD display output.
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned GATE_CYCLES = DefaultGateCycles
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CH-1:0]                sig_in,
  input  logic [sel_width(N_CH)-1:0]     ch_sel,
  input  logic                           hold,
  output logic [BcdW*DIGITS-1:0]         bcd_out,
  output logic                           ovf_out,
  output logic                           valid,
  output logic                           gate_tick
);

  localparam int unsigned CntW  = BcdW * DIGITS;
  localparam int unsigned GateW = $clog2(GATE_CYCLES);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

  logic [N_CH-1:0]  sync1_q, sync2_q, sync3_q;
  logic [N_CH-1:0]  rise;
  logic [GateW-1:0] gate_q;
  logic             tick;
  logic [CntW-1:0]  cnt_next [N_CH];
  logic [N_CH-1:0]  ovf_next;
  logic [CntW-1:0]  res_q [N_CH];
  logic [N_CH-1:0]  res_ovf_q;
  logic             valid_q;
  logic [CntW-1:0]  sel_bcd;
  logic             sel_ovf;

  assign rise = sync2_q & ~sync3_q;
  assign tick = (gate_q == GateLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      gate_q  <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      gate_q  <= tick ? '0 : gate_q + 1'b1;
    end
  end

  // Counters clear at the window boundary whatever hold says; hold only gates the latch.
  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    bcd_sat_counter #(
      .DIGITS(DIGITS)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (tick),
      .inc       (rise[g]),
      .count_next(cnt_next[g]),
      .ovf_next  (ovf_next[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) res_q[i] <= '0;
      res_ovf_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= tick & ~hold;
      if (tick && !hold) begin
        for (int i = 0; i < N_CH; i++) res_q[i] <= cnt_next[i];
        res_ovf_q <= ovf_next;
      end
    end
  end

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sel_bcd = res_q[0];
    sel_ovf = res_ovf_q[0];
    for (int i = 1; i < N_CH; i++) begin
      if (int'(ch_sel) == i) begin
        sel_bcd = res_q[i];
        sel_ovf = res_ovf_q[i];
      end
    end
  end

  assign bcd_out   = rst ? '0 : sel_bcd;
  assign ovf_out   = sel_ovf & ~rst;
  assign valid     = valid_q & ~rst;
  assign gate_tick = tick & ~rst;

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed bench for freq_meter_mc: a 2-channel 4-digit meter and a 3-channel
// 2-digit meter share clock, reset and input pins with a 1000-cycle gate.
module tb_freq_meter_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pins;
  logic       ch_sel;
  logic       hold;
  logic [15:0] bcd;
  logic       ovf, valid, gtick;
  logic [1:0] ch_sel2;
  logic       hold2;
  logic [7:0] bcd2;
  logic       ovf2, valid2, gtick2;

  int cyc, vcnt, checks, errs;

  always #5 clk = ~clk;

  freq_meter_mc #(
    .N_CH(2), .DIGITS(4), .GATE_CYCLES(1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (pins[1:0]),
    .ch_sel   (ch_sel),
    .hold     (hold),
    .bcd_out  (bcd),
    .ovf_out  (ovf),
    .valid    (valid),
    .gate_tick(gtick)
  );

  freq_meter_mc #(
    .N_CH(3), .DIGITS(2), .GATE_CYCLES(1000)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (pins),
    .ch_sel   (ch_sel2),
    .hold     (hold2),
    .bcd_out  (bcd2),
    .ovf_out  (ovf2),
    .valid    (valid2),
    .gate_tick(gtick2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cyc is the index of the cycle we are in; vcnt counts observed valid pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) vcnt++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // n0 rising edges on pin 0 and n1 on pin 1, period 4 cycles, starting now.
  task automatic edges(input int n0, input int n1);
    int n;
    n = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < n; i++) begin
      pins = {1'b0, (i < n1) ? 1'b1 : 1'b0, (i < n0) ? 1'b1 : 1'b0};
      tick();
      tick();
      pins = '0;
      tick();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; pins = '0; ch_sel = 1'b0; hold = 1'b0;
    ch_sel2 = 2'd1; hold2 = 1'b0;
    cyc = 0; vcnt = 0; checks = 0; errs = 0;
    repeat (3) tick();
    chk("reset_bcd", 32'(bcd), 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_gate_tick", 32'(gtick), 32'h0);
    chk("reset_bcd2", 32'(bcd2), 32'h0);

    // Window 0: 250 edges on both channels.
    rst = 1'b0; cyc = 0; vcnt = 0;
    edges(250, 250);
    chk("w0_valid", 32'(valid), 32'h1);
    chk("w0_valid_count", 32'(vcnt), 32'h1);
    chk("w0_bcd", 32'(bcd), 32'h0250);
    chk("w0_ovf", 32'(ovf), 32'h0);
    chk("w0_sat_bcd2", 32'(bcd2), 32'h99);
    chk("w0_sat_ovf2", 32'(ovf2), 32'h1);
    tick();
    chk("w0_valid_one_cycle", 32'(valid), 32'h0);

    // Window 1: held, 100 edges on ch0, no edges on ch1.
    hold = 1'b1;
    edges(100, 0);
    run_to(1999);
    chk("w1_gate_tick", 32'(gtick), 32'h1);
    chk("w1_valid_before", 32'(valid), 32'h0);
    tick();
    chk("w1_hold_no_valid", 32'(valid), 32'h0);
    chk("w1_hold_bcd", 32'(bcd), 32'h0250);
    chk("w1_valid2", 32'(valid2), 32'h1);
    chk("w1_clear_bcd2", 32'(bcd2), 32'h00);
    chk("w1_clear_ovf2", 32'(ovf2), 32'h0);

    // Window 2: 100 edges, hold pulsed mid-window only.
    hold = 1'b0;
    edges(100, 0);
    run_to(2500);
    hold = 1'b1;
    run_to(2700);
    hold = 1'b0;
    run_to(3000);
    chk("w2_valid", 32'(valid), 32'h1);
    chk("w2_bcd", 32'(bcd), 32'h0100);

    // Window 3: 123 edges on ch0, 45 on ch1.
    edges(123, 45);
    run_to(4000);
    chk("w3_valid", 32'(valid), 32'h1);
    chk("w3_ch0", 32'(bcd), 32'h0123);
    ch_sel = 1'b1;
    #1;
    chk("w3_ch1", 32'(bcd), 32'h0045);
    chk("w3_ch1_ovf", 32'(ovf), 32'h0);
    chk("w3_ch1_same_valid", 32'(valid), 32'h1);
    ch_sel = 1'b0;
    ch_sel2 = 2'd3;
    #1;
    chk("w3_sel_oob_bcd2", 32'(bcd2), 32'h99);
    chk("w3_sel_oob_ovf2", 32'(ovf2), 32'h1);
    ch_sel2 = 2'd2;
    #1;
    chk("w3_ch2_bcd2", 32'(bcd2), 32'h00);
    ch_sel2 = 2'd1;

    // Window 4: ch0 edge detected on the gate_tick cycle, ch1 edge one cycle later.
    run_to(4997);
    pins = 3'b001;
    tick();
    pins = 3'b011;
    tick();
    chk("w4_gate_tick", 32'(gtick), 32'h1);
    pins = 3'b010;
    tick();
    pins = 3'b000;
    chk("w4_last_edge_ch0", 32'(bcd), 32'h0001);
    ch_sel = 1'b1;
    #1;
    chk("w4_late_edge_ch1", 32'(bcd), 32'h0000);
    ch_sel = 1'b0;
    run_to(6000);
    chk("w5_ch0_restart", 32'(bcd), 32'h0000);
    ch_sel = 1'b1;
    #1;
    chk("w5_ch1_late_edge", 32'(bcd), 32'h0001);

    // Window 6: reset mid-window after 125 edges.
    edges(125, 0);
    rst = 1'b1;
    tick();
    chk("midrst_bcd", 32'(bcd), 32'h0);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_gate_tick", 32'(gtick), 32'h0);
    rst = 1'b0; cyc = 0; vcnt = 0; ch_sel = 1'b0;
    edges(7, 0);
    run_to(999);
    chk("postrst_gate_tick", 32'(gtick), 32'h1);
    chk("postrst_no_early_valid", 32'(vcnt), 32'h0);
    tick();
    chk("postrst_valid", 32'(valid), 32'h1);
    chk("postrst_bcd", 32'(bcd), 32'h0007);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
